// File: rtl/amo_sequencer_pkg.sv
// Shared RISC-V / sequencer types for the RV32A atomic sequencer.
// Holds the AMO opcodes, exception codes, FSM states and the latched request.
package amo_sequencer_pkg;

  // RV32A funct5 encodings
  typedef enum logic [4:0] {
    AmoAdd  = 5'b00000,
    AmoSwap = 5'b00001,
    AmoLr   = 5'b00010,
    AmoSc   = 5'b00011,
    AmoXor  = 5'b00100,
    AmoOr   = 5'b01000,
    AmoAnd  = 5'b01100,
    AmoMin  = 5'b10000,
    AmoMax  = 5'b10100,
    AmoMinu = 5'b11000,
    AmoMaxu = 5'b11100
  } amo_t;

  typedef enum logic [4:0] {
    ExcInstAddrMisaligned     = 5'd0,
    ExcIllegalInst            = 5'd2,
    ExcStoreAmoAddrMisaligned = 5'd6
  } exception_code_t;

  typedef enum logic [2:0] {
    StIdle,
    StReadReq,
    StReadWait,
    StWriteReq,
    StResult
  } amo_seq_state_t;

  // Widest instruction ID the request struct can carry.
  localparam int unsigned AmoIdMaxW = 8;

  typedef struct packed {
    amo_t                 op;
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [AmoIdMaxW-1:0] id;
  } amo_request_t;

  function automatic logic is_amo_op(input logic [4:0] fn5);
    case (fn5)
      AmoAdd, AmoSwap, AmoLr, AmoSc, AmoXor, AmoOr, AmoAnd,
      AmoMin, AmoMax, AmoMinu, AmoMaxu: is_amo_op = 1'b1;
      default:                          is_amo_op = 1'b0;
    endcase
  endfunction

  function automatic logic same_granule(input logic [31:0] a, input logic [31:0] b,
                                        input int unsigned gran_w);
    same_granule = ((a >> gran_w) == (b >> gran_w));
  endfunction

endpackage

// File: rtl/amo_sequencer_alu.sv
// Combinational AMO compute: new memory value from the old value and rs2.
// Kept standalone so a cache-side AMO unit can reuse it.
module amo_sequencer_alu
  import amo_sequencer_pkg::*;
(
  input  amo_t        op,
  input  logic [31:0] old_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] new_data
);

  always_comb begin
    new_data = rs2_data;
    case (op)
      AmoAdd:  new_data = old_data + rs2_data;
      AmoXor:  new_data = old_data ^ rs2_data;
      AmoAnd:  new_data = old_data & rs2_data;
      AmoOr:   new_data = old_data | rs2_data;
      AmoMin:  new_data = ($signed(old_data) <= $signed(rs2_data)) ? old_data : rs2_data;
      AmoMax:  new_data = ($signed(old_data) >= $signed(rs2_data)) ? old_data : rs2_data;
      AmoMinu: new_data = (old_data <= rs2_data) ? old_data : rs2_data;
      AmoMaxu: new_data = (old_data >= rs2_data) ? old_data : rs2_data;
      default: new_data = rs2_data;  // SWAP; LR never writes, SC writes rs2 directly
    endcase
  end

endmodule

// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: runs one AMO/LR/SC at a time as read/modify/write on a
// single-ported data memory and holds the single LR/SC reservation.
module amo_sequencer
  import amo_sequencer_pkg::*;
#(
  parameter int unsigned ID_W       = 3,  // must not exceed AmoIdMaxW
  parameter int unsigned RES_GRAN_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_data,
  input  logic [ID_W-1:0] req_id,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  input  logic            snoop_valid,
  input  logic [31:0]     snoop_addr,
  output logic            result_valid,
  output logic [31:0]     result_data,
  output logic [ID_W-1:0] result_id,
  output logic            result_exception,
  output logic [4:0]      result_ecode,
  output logic            reservation_valid
);

  amo_seq_state_t  state_q;
  amo_request_t    req_q;
  logic [31:0]     new_q;
  logic [31:0]     rd_q;
  logic            exc_q;
  exception_code_t ecode_q;
  logic            res_valid_q;
  logic [31:0]     res_addr_q;
  logic [31:0]     alu_new;

  logic accept;
  logic sc_accept;
  logic sc_success;
  logic lr_set;
  logic snoop_hits_res;
  logic snoop_hits_req;
  logic snoop_hits_lr;
  logic unused_id_bits;

  amo_sequencer_alu u_alu (
    .op       (req_q.op),
    .old_data (mem_rdata),
    .rs2_data (req_q.data),
    .new_data (alu_new)
  );

  assign accept         = (state_q == StIdle) && req_valid;
  assign sc_accept      = accept && (req_op == AmoSc);
  assign snoop_hits_res = snoop_valid && same_granule(snoop_addr, res_addr_q, RES_GRAN_W);
  assign snoop_hits_req = snoop_valid && same_granule(snoop_addr, req_addr, RES_GRAN_W);
  assign snoop_hits_lr  = snoop_valid && same_granule(snoop_addr, req_q.addr, RES_GRAN_W);
  // A snoop landing in the same cycle as the SC kills it even though the flop hasn't cleared yet.
  assign sc_success     = res_valid_q && same_granule(req_addr, res_addr_q, RES_GRAN_W) &&
                          !snoop_hits_req;
  assign lr_set         = (state_q == StReadWait) && mem_rvalid && (req_q.op == AmoLr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      new_q   <= '0;
      rd_q    <= '0;
      exc_q   <= 1'b0;
      ecode_q <= exception_code_t'('0);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_q <= '{op: amo_t'(req_op), addr: req_addr, data: req_data,
                       id: AmoIdMaxW'(req_id)};
            exc_q <= 1'b0;
            rd_q  <= '0;
            if (req_addr[1:0] != 2'b00) begin
              exc_q   <= 1'b1;
              ecode_q <= ExcStoreAmoAddrMisaligned;
              state_q <= StResult;
            end else if (!is_amo_op(req_op)) begin
              exc_q   <= 1'b1;
              ecode_q <= ExcIllegalInst;
              state_q <= StResult;
            end else if (req_op == AmoSc) begin
              if (sc_success) begin
                new_q   <= req_data;
                state_q <= StWriteReq;
              end else begin
                rd_q    <= 32'd1;
                state_q <= StResult;
              end
            end else begin
              state_q <= StReadReq;
            end
          end
        end
        StReadReq: begin
          if (mem_req_ready) state_q <= StReadWait;
        end
        StReadWait: begin
          if (mem_rvalid) begin
            rd_q    <= mem_rdata;
            new_q   <= alu_new;
            state_q <= (req_q.op == AmoLr) ? StResult : StWriteReq;
          end
        end
        StWriteReq: begin
          if (mem_req_ready) state_q <= StResult;
        end
        StResult: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
    end else if (lr_set) begin
      res_valid_q <= !snoop_hits_lr;
      res_addr_q  <= req_q.addr;
    end else if (sc_accept || snoop_hits_res) begin
      res_valid_q <= 1'b0;
    end
  end

  assign req_ready         = (state_q == StIdle);
  assign mem_req_valid     = (state_q == StReadReq) || (state_q == StWriteReq);
  assign mem_we            = (state_q == StWriteReq);
  assign mem_addr          = req_q.addr & 32'hFFFF_FFFC;
  assign mem_wdata         = new_q;
  assign result_valid      = (state_q == StResult);
  assign result_data       = rd_q;
  assign result_id         = req_q.id[ID_W-1:0];
  assign result_exception  = exc_q;
  assign result_ecode      = ecode_q;
  assign reservation_valid = res_valid_q;

  assign unused_id_bits = ^(req_q.id >> ID_W);

endmodule
